// File: rtl/mem_pipelined_if.sv
// Request/response bundle between the memory controller and mem_pipelined.
// The controller drives requests; the memory returns data, strobes and ready.
interface mem_pipelined_if #(
    parameter int BUSWIDTH = 32,
    parameter int MEMSIZE  = 256
);
    localparam int ADDRWIDTH = $clog2(MEMSIZE);
    localparam int NBYTES    = BUSWIDTH / 8;

    logic                 rdEn;
    logic                 wrEn;
    logic [ADDRWIDTH-1:0] Addr;
    logic [BUSWIDTH-1:0]  DataIn;
    logic [NBYTES-1:0]    ByteEn;
    logic [BUSWIDTH-1:0]  DataOut;
    logic                 rdValid;
    logic                 ready;
    logic                 addrErr;

    modport master (
        output rdEn, wrEn, Addr, DataIn, ByteEn,
        input  DataOut, rdValid, ready, addrErr
    );

    modport slave (
        input  rdEn, wrEn, Addr, DataIn, ByteEn,
        output DataOut, rdValid, ready, addrErr
    );
endinterface

// File: rtl/mem_pipelined.sv
// Byte-lane synchronous memory with a RDLATENCY-deep read pipeline, write-first
// read/write collision handling, out-of-range detection and a post-reset clear sequencer.
module mem_pipelined_lane #(
    parameter int MEMSIZE   = 256,
    parameter int ADDRWIDTH = 8,
    parameter int RDLATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_en,
    input  logic [ADDRWIDTH-1:0] clr_addr,
    input  logic                 wr_en,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic [7:0]           din,
    input  logic                 in_range,
    input  logic                 load,
    output logic [7:0]           dout
);
    logic [7:0]                 mem [MEMSIZE];
    logic [7:0]                 rd_byte;
    logic [RDLATENCY:1][7:0]    d_q;
    logic [RDLATENCY:1][7:0]    d_nxt;

    always_ff @(posedge clk) begin
        if (clr_en)
            mem[clr_addr] <= 8'h00;
        else if (wr_en)
            mem[addr] <= din;
    end

    // Write-first: a colliding write's enabled byte is what the read captures.
    assign rd_byte = wr_en ? din : (in_range ? mem[addr] : 8'h00);

    for (genvar g = 1; g <= RDLATENCY; g++) begin : g_nxt
        if (g == 1) begin : g_first
            assign d_nxt[g] = rd_byte;
        end else begin : g_rest
            assign d_nxt[g] = d_q[g-1];
        end
    end

    // Only the output stage is qualified so DataOut holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= '0;
        end else begin
            for (int s = 1; s < RDLATENCY; s++)
                d_q[s] <= d_nxt[s];
            if (load)
                d_q[RDLATENCY] <= d_nxt[RDLATENCY];
        end
    end

    assign dout = d_q[RDLATENCY];
endmodule

module mem_pipelined #(
    parameter int BUSWIDTH       = 32,
    parameter int MEMSIZE        = 256,
    parameter int RDLATENCY      = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic              clk,
    input logic              resetH,
    mem_pipelined_if.slave   bus
);
    localparam int ADDRWIDTH = $clog2(MEMSIZE);
    localparam int NBYTES    = BUSWIDTH / 8;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(MEMSIZE - 1);

    logic [0:0]                 state;
    logic [ADDRWIDTH-1:0]       clr_addr;
    logic                       ready_q;
    logic                       in_range;
    logic                       rd_issue;
    logic                       wr_issue;
    logic                       err_issue;
    logic                       clr_en;
    logic [RDLATENCY:0]         vld_pipe;
    logic [RDLATENCY:0]         err_pipe;
    logic [RDLATENCY:1]         vld_q;
    logic [RDLATENCY:1]         err_q;
    logic [NBYTES-1:0][7:0]     dout_b;

    assign in_range  = {1'b0, bus.Addr} < (ADDRWIDTH + 1)'(MEMSIZE);
    assign rd_issue  = ready_q & bus.rdEn;
    assign wr_issue  = ready_q & bus.wrEn & in_range;
    assign err_issue = ready_q & (bus.rdEn | bus.wrEn) & ~in_range;
    assign clr_en    = (state == ST_CLEAR) & ~resetH;

    assign vld_pipe = {vld_q, rd_issue};
    assign err_pipe = {err_q, err_issue};

    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_addr <= '0;
            ready_q  <= 1'b0;
            vld_q    <= '0;
            err_q    <= '0;
        end else begin
            vld_q <= vld_pipe[RDLATENCY-1:0];
            err_q <= err_pipe[RDLATENCY-1:0];
            case (state)
                ST_CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state   <= ST_READY;
                        ready_q <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + ADDRWIDTH'(1);
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    for (genvar i = 0; i < NBYTES; i++) begin : g_lane
        mem_pipelined_lane #(
            .MEMSIZE   (MEMSIZE),
            .ADDRWIDTH (ADDRWIDTH),
            .RDLATENCY (RDLATENCY)
        ) u_lane (
            .clk      (clk),
            .rst      (resetH),
            .clr_en   (clr_en),
            .clr_addr (clr_addr),
            .wr_en    (wr_issue & bus.ByteEn[i]),
            .addr     (bus.Addr),
            .din      (bus.DataIn[8*i +: 8]),
            .in_range (in_range),
            .load     (vld_pipe[RDLATENCY-1]),
            .dout     (dout_b[i])
        );
    end

    assign bus.DataOut = dout_b;
    assign bus.rdValid = vld_q[RDLATENCY];
    assign bus.addrErr = err_q[RDLATENCY];
    assign bus.ready   = ready_q;
endmodule
